blk_mem_pipe: RTL and testbench

- Single-clock, single-port block-memory wrapper with a ready/valid request channel and a ready/valid response channel.
- Unlike the previous blocking wrapper, reads are fully pipelined: one read per cycle at any READ_LATENCY.
- Responses are buffered, so the consumer may back-pressure without losing data.
- Width, depth and latency are parameters. It sits between PE/GLB controllers and on-chip SRAM.

---
 rtl/blk_mem_pipe.sv | 130 +++++++++++++
 tb/tb_blk_mem_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blk_mem_pipe.sv
// blk_mem_pipe: single-port block memory behind a ready/valid request channel.
// Reads are pipelined at one per cycle. Each read is counted against a credit
// limit (outstanding_q) sized to the response FIFO, so a stalled consumer can
// never cause a response to be dropped.
module blk_mem_pipe #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [DATA_WIDTH/8-1:0] req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    busy
);

  localparam int NB        = DATA_WIDTH / 8;
  localparam int BOFF      = $clog2(NB);
  localparam int IW        = ADDR_WIDTH - BOFF;
  localparam int DEPTH     = 2 ** IW;
  localparam int RSP_DEPTH = READ_LATENCY + 1;
  localparam int PW        = $clog2(RSP_DEPTH);
  localparam int CW        = $clog2(RSP_DEPTH + 1);

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
      $error("blk_mem_pipe: READ_LATENCY must lie within 1..8");
    end
    if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
      $error("blk_mem_pipe: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (BOFF > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^req_addr[BOFF-1:0];
    end
  endgenerate

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [IW-1:0]           idx;
  logic                    acc;
  logic                    rd_acc;
  logic                    wr_acc;
  logic [CW-1:0]           outstanding_q;
  logic [READ_LATENCY-1:0] pipe_v;
  logic [DATA_WIDTH-1:0]   pipe_d [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   fifo_mem [RSP_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           count_q;
  logic                    tail_v;
  logic [DATA_WIDTH-1:0]   tail_d;
  logic                    fifo_empty;
  logic                    bypass;
  logic                    push;
  logic                    fifo_pop;
  logic                    pop;

  assign idx       = req_addr[ADDR_WIDTH-1:BOFF];
  assign req_ready = !arst && (outstanding_q < CW'(RSP_DEPTH));
  assign acc       = req_valid && req_ready;
  assign rd_acc    = acc && (req_we == '0);
  assign wr_acc    = acc && (req_we != '0);

  // The last pipeline stage is presented directly while the FIFO is empty.
  // This keeps the latency at READ_LATENCY and gives one read per cycle
  // when the consumer never stalls.
  assign tail_v     = pipe_v[READ_LATENCY-1];
  assign tail_d     = pipe_d[READ_LATENCY-1];
  assign fifo_empty = (count_q == '0);
  assign rsp_valid  = !fifo_empty || tail_v;
  assign rsp_rdata  = fifo_empty ? tail_d : fifo_mem[rd_ptr];
  assign pop        = rsp_valid && rsp_ready;
  assign bypass     = fifo_empty && tail_v && rsp_ready;
  assign push       = tail_v && !bypass;
  assign fifo_pop   = pop && !fifo_empty;
  assign busy       = (outstanding_q != '0);

  // Byte-masked writes and the array read that starts the read data pipeline
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (wr_acc && req_we[b]) mem[idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
    end
    if (rd_acc) pipe_d[0] <= mem[idx];
    for (int i = 1; i < READ_LATENCY; i++) pipe_d[i] <= pipe_d[i-1];
  end

  // Valid bits of the read pipeline; cleared on reset so in-flight reads vanish
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= rd_acc;
      for (int i = 1; i < READ_LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  // Response FIFO storage, written only when the consumer cannot take the tail directly
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= tail_d;
  end

  // FIFO pointers wrap at RSP_DEPTH, which need not be a power of two; fullness comes from count_q
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (fifo_pop) rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count_q <= count_q + CW'(push) - CW'(fifo_pop);
    end
  end

  // Read credits: taken when a read is accepted, returned when its response is popped
  always_ff @(posedge clk or posedge arst) begin
    if (arst) outstanding_q <= '0;
    else      outstanding_q <= outstanding_q + CW'(rd_acc) - CW'(pop);
  end

  assert property (@(posedge clk) disable iff (arst) outstanding_q <= CW'(RSP_DEPTH))
    else $error("blk_mem_pipe: outstanding_q exceeded RSP_DEPTH");

endmodule

// File: tb/tb_blk_mem_pipe.sv
// tb_blk_mem_pipe: scoreboard bench for blk_mem_pipe at READ_LATENCY 3, 1 and 8.
// Three instances share the clock. They are exercised one at a time, selected by 'cur'.
module tb_blk_mem_pipe;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] acc_cyc;
  } sb_item_t;

  logic        clk;
  logic [2:0]  arst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [3:0]  req_we    [3];
  logic [9:0]  req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_ready;
  logic [31:0] rsp_rdata [3];
  logic [2:0]  busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pops   = 0;
  int          cyc      = 0;
  int          cur      = 0;
  bit          check_lat = 0;
  logic [31:0] model [3][256];
  sb_item_t    exp_q [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    blk_mem_pipe #(
      .ADDR_WIDTH  (10),
      .DATA_WIDTH  (32),
      .READ_LATENCY((g == 0) ? 3 : (g == 1) ? 1 : 8)
    ) dut (
      .clk      (clk),
      .arst     (arst[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we   (req_we[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .busy     (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int k);
    return (k == 0) ? 3 : (k == 1) ? 1 : 8;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (latency %0d, cycle %0d)",
               tag, got, exp, lat_of(cur), cyc);
    end
  endtask

  // Scoreboard: responses pop expected items in order; nothing may be valid when none are expected
  always @(negedge clk) begin
    sb_item_t it;
    if (exp_q.size() == 0) begin
      checkOutput("no_rsp_pending", 32'(rsp_valid[cur]), 32'd0);
    end else if (rsp_valid[cur] && rsp_ready[cur]) begin
      it = exp_q.pop_front();
      checkOutput("rsp_data", rsp_rdata[cur], it.data);
      if (check_lat) checkOutput("rsp_latency", 32'(cyc + 1) - it.acc_cyc, 32'(lat_of(cur)));
      n_pops++;
    end
  end

  task automatic push_read(input logic [9:0] addr);
    sb_item_t it;
    it.data    = model[cur][addr[9:2]];
    it.acc_cyc = 32'(cyc + 1);
    exp_q.push_back(it);
  endtask

  // Offer one request from posedge+1 and hold it until accepted; returns at posedge+1 after the accept edge
  task automatic applyStimulus(input logic [3:0] we, input logic [9:0] addr,
                               input logic [31:0] wdata, output int waits);
    logic [7:0] wi;
    req_valid[cur] = 1'b1;
    req_we[cur]    = we;
    req_addr[cur]  = addr;
    req_wdata[cur] = wdata;
    wi    = addr[9:2];
    waits = 0;
    forever begin
      @(negedge clk);
      if (req_ready[cur]) begin
        if (we == 4'h0) begin
          push_read(addr);
        end else begin
          for (int b = 0; b < 4; b++)
            if (we[b]) model[cur][wi][b*8 +: 8] = wdata[b*8 +: 8];
        end
        @(posedge clk); #1;
        break;
      end
      waits++;
      if (waits > 100) begin
        checkOutput("req_accept_timeout", 32'(req_ready[cur]), 32'd1);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    req_valid[cur] = 1'b0;
    req_we[cur]    = 4'h0;
  endtask

  task automatic wait_rsp();
    int c;
    c = 0;
    @(negedge clk);
    while (!rsp_valid[cur] && c < 40) begin
      @(negedge clk);
      c++;
    end
    if (!rsp_valid[cur]) checkOutput("rsp_timeout", 32'(rsp_valid[cur]), 32'd1);
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    if (exp_q.size() != 0) checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic test_writeback();
    int w;
    rsp_ready[cur] = 1'b1;
    check_lat      = 1'b1;
    applyStimulus(4'hF, 10'h010, 32'hDEADBEEF, w);
    applyStimulus(4'h0, 10'h010, 32'h0, w);
    idle();
    wait_rsp();
    checkOutput("wb_data", rsp_rdata[cur], 32'hDEADBEEF);
    checkOutput("wb_busy_before_pop", 32'(busy[cur]), 32'd1);
    @(negedge clk);
    checkOutput("wb_busy_after_pop", 32'(busy[cur]), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic test_bytemask();
    int w;
    applyStimulus(4'hF, 10'h020, 32'h11223344, w);
    applyStimulus(4'b0101, 10'h023, 32'hAABBCCDD, w);
    applyStimulus(4'h0, 10'h020, 32'h0, w);
    idle();
    wait_rsp();
    checkOutput("byte_mask", rsp_rdata[cur], 32'h11BB33DD);
    @(posedge clk); #1;
    wait_drain();
  endtask

  // A read accepted just before a write to the same word sees the old data
  task automatic test_hazard();
    int w;
    applyStimulus(4'hF, 10'h030, 32'h01234567, w);
    applyStimulus(4'h0, 10'h030, 32'h0, w);
    applyStimulus(4'hF, 10'h030, 32'h89ABCDEF, w);
    applyStimulus(4'h0, 10'h030, 32'h0, w);
    idle();
    wait_drain();
  endtask

  task automatic run_stream();
    int w;
    int p0;
    rsp_ready[cur] = 1'b1;
    check_lat      = 1'b0;
    for (int i = 0; i < 64; i++)
      applyStimulus(4'hF, 10'(i * 4), {8'(cur + 1), 8'(i), 16'(16'hBEEF ^ (i * 37))}, w);
    idle();
    check_lat = 1'b1;
    p0 = n_pops;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(4'h0, 10'(i * 4), 32'h0, w);
      if (i > 0) checkOutput("stream_ready_wait", 32'(w), 32'd0);
    end
    idle();
    wait_drain();
    checkOutput("stream_count", 32'(n_pops - p0), 32'd64);
    check_lat = 1'b0;
  endtask

  task automatic run_stall();
    int lat;
    int acc_n;
    int p0;
    lat   = lat_of(cur);
    acc_n = 0;
    p0    = n_pops;
    rsp_ready[cur] = 1'b0;
    check_lat      = 1'b0;
    req_we[cur]    = 4'h0;
    req_wdata[cur] = 32'h0;
    for (int c = 0; c < lat + 7; c++) begin
      req_valid[cur] = (acc_n < 10);
      req_addr[cur]  = 10'(acc_n * 4);
      @(negedge clk);
      if (req_valid[cur] && req_ready[cur]) begin
        push_read(req_addr[cur]);
        acc_n++;
      end
      @(posedge clk); #1;
    end
    checkOutput("stall_accepts", 32'(acc_n), 32'(lat + 1));
    @(negedge clk);
    checkOutput("stall_req_ready", 32'(req_ready[cur]), 32'd0);
    checkOutput("stall_rsp_valid", 32'(rsp_valid[cur]), 32'd1);
    checkOutput("stall_busy", 32'(busy[cur]), 32'd1);
    @(posedge clk); #1;
    idle();
    rsp_ready[cur] = 1'b1;
    wait_drain();
    checkOutput("stall_drained", 32'(n_pops - p0), 32'(lat + 1));
    @(negedge clk);
    checkOutput("stall_ready_back", 32'(req_ready[cur]), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int w;
    rsp_ready[cur] = 1'b0;
    check_lat      = 1'b0;
    applyStimulus(4'h0, 10'h010, 32'h0, w);
    applyStimulus(4'h0, 10'h020, 32'h0, w);
    applyStimulus(4'h0, 10'h004, 32'h0, w);
    idle();
    checkOutput("inflight_rsp_valid", 32'(rsp_valid[cur]), 32'd1);
    arst[cur] = 1'b1;
    #1;
    checkOutput("rst_rsp_valid", 32'(rsp_valid[cur]), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready[cur]), 32'd0);
    checkOutput("rst_busy", 32'(busy[cur]), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    arst[cur]      = 1'b0;
    rsp_ready[cur] = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_req_ready", 32'(req_ready[cur]), 32'd1);
    for (int c = 0; c < lat_of(cur) + 4; c++) begin
      checkOutput("post_rst_quiet", 32'(rsp_valid[cur]), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    check_lat = 1'b1;
    applyStimulus(4'h0, 10'h010, 32'h0, w);
    idle();
    wait_drain();
    check_lat = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    arst      = 3'b111;
    req_valid = '0;
    rsp_ready = '0;
    for (int k = 0; k < 3; k++) begin
      req_we[k]    = 4'h0;
      req_addr[k]  = 10'h0;
      req_wdata[k] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      cur = k;
      checkOutput("reset_req_ready", 32'(req_ready[k]), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      checkOutput("reset_busy", 32'(busy[k]), 32'd0);
    end
    cur  = 0;
    arst = 3'b000;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cur = k;
      checkOutput("release_req_ready", 32'(req_ready[k]), 32'd1);
    end
    cur = 0;
    @(posedge clk); #1;

    $display("[TB] READ_LATENCY=3 instance");
    test_writeback();
    test_bytemask();
    test_hazard();
    run_stream();
    run_stall();
    test_reset();

    for (int k = 1; k < 3; k++) begin
      cur = k;
      $display("[TB] READ_LATENCY=%0d instance", lat_of(k));
      run_stream();
      run_stall();
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
